// File: rtl/parlante_pkg.sv
// Shared types, widths and the note half-period table for the parlante note sequencer.
package parlante_pkg;

    localparam int NOTE_W = 5;
    localparam int DUR_W  = 11;
    localparam int CONT_W = 29;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_GAP
    } state_t;

    // Half-period count for chromatic note idx (1 = C4 .. 24 = B5); rests return 0.
    function automatic logic [CONT_W-1:0] note_to_cont(input int idx, input int clk_hz);
        real f;
        real c;
        if (idx < 1 || idx > 24) begin
            return '0;
        end
        f = 261.63;
        for (int unsigned i = 1; i < 32'(idx); i++) begin
            f = f * 1.0594630943592953;
        end
        c = real'(clk_hz) / (2.0 * f);
        return CONT_W'($rtoi(c + 0.5));
    endfunction

endpackage

// File: rtl/parlante_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full is accepted only alongside a pop.
module parlante_fifo
    import parlante_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [LW-1:0]    r_cnt;
    logic             w_do_pop;
    logic             w_do_push;

    assign full      = (r_cnt == LW'(DEPTH));
    assign empty     = (r_cnt == '0);
    assign level     = r_cnt;
    assign dout      = r_mem[r_rp];
    assign w_do_pop  = pop && !empty;
    // When full, the slot being vacated by the head is exactly where the new word lands.
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_do_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wp] <= din;
        end
    end

endmodule

// File: rtl/parlante_seq.sv
// Note sequencer: plays queued (note, duration) entries back-to-back into the speaker divider.
module parlante_seq
    import parlante_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_MS     = 20
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [NOTE_W-1:0]             wr_note,
    input  logic [DUR_W-1:0]              wr_dur,
    input  logic                          stop,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy,
    output logic                          ovf,
    output logic [CONT_W-1:0]             max_cont,
    output logic                          tone_en
);

    localparam int MS_CYC = CLK_HZ / 1000;
    localparam int PW     = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
    localparam int LW     = $clog2(FIFO_DEPTH) + 1;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [PW-1:0]             r_presc;
    logic [DUR_W-1:0]          r_ms;
    logic [CONT_W-1:0]         r_max_cont;
    logic                      r_tone_en;
    logic                      r_ovf;
    logic [CONT_W-1:0]         w_table [32];
    logic [NOTE_W+DUR_W-1:0]   w_head;
    logic [NOTE_W-1:0]         w_head_note;
    logic [DUR_W-1:0]          w_head_dur;
    logic [CONT_W-1:0]         w_head_cont;
    logic                      w_head_rest;
    logic                      w_empty;
    logic                      w_full;
    logic [LW-1:0]             w_level;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_tick;
    logic                      w_last;

    for (genvar g = 0; g < 32; g++) begin : g_tab
        localparam logic [CONT_W-1:0] C_VAL = note_to_cont(g, CLK_HZ);
        assign w_table[g] = C_VAL;
    end

    parlante_fifo #(
        .WIDTH (NOTE_W + DUR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stop),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({wr_note, wr_dur}),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    assign w_head_note = w_head[NOTE_W+DUR_W-1:DUR_W];
    assign w_head_dur  = w_head[DUR_W-1:0];
    assign w_head_cont = w_table[w_head_note];
    assign w_head_rest = (w_head_cont == '0);
    assign w_push      = wr_en && !stop;
    assign w_pop       = (r_state == ST_LOAD) && !stop;
    assign w_tick      = (r_presc == PW'(MS_CYC - 1));
    assign w_last      = w_tick && (r_ms == DUR_W'(1));

    assign full     = w_full;
    assign level    = w_level;
    assign busy     = (r_state != ST_IDLE) || !w_empty;
    assign ovf      = r_ovf;
    assign max_cont = r_max_cont;
    assign tone_en  = r_tone_en;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_head_dur == '0) begin
                    w_state_nxt = (w_level > LW'(1)) ? ST_LOAD : ST_IDLE;
                end else begin
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (w_last) begin
                    if (GAP_MS != 0) begin
                        w_state_nxt = ST_GAP;
                    end else begin
                        w_state_nxt = w_empty ? ST_IDLE : ST_LOAD;
                    end
                end
            end
            ST_GAP: begin
                if (w_last) begin
                    w_state_nxt = w_empty ? ST_IDLE : ST_LOAD;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_presc    <= '0;
            r_ms       <= '0;
            r_max_cont <= '0;
            r_tone_en  <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (stop) begin
            r_state   <= ST_IDLE;
            r_presc   <= '0;
            r_ms      <= '0;
            r_tone_en <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (wr_en && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
            case (r_state)
                ST_LOAD: begin
                    r_presc <= '0;
                    if (w_head_dur != '0) begin
                        r_ms      <= w_head_dur;
                        r_tone_en <= !w_head_rest;
                        if (!w_head_rest) begin
                            r_max_cont <= w_head_cont;
                        end
                    end
                end
                // Prescaler restarts on entry to GAP so the gap is whole milliseconds.
                ST_PLAY: begin
                    if (w_last) begin
                        r_tone_en <= 1'b0;
                        r_ms      <= DUR_W'(GAP_MS);
                        r_presc   <= '0;
                    end else if (w_tick) begin
                        r_ms    <= r_ms - 1'b1;
                        r_presc <= '0;
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (w_tick) begin
                        r_ms    <= r_ms - 1'b1;
                        r_presc <= '0;
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
                default: r_presc <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_parlante_seq.sv
// Bench for parlante_seq: queue-and-timer reference model checked every cycle, plus directed timing pins.
module tb_parlante_seq;

    localparam int CLK_HZ = 10_000;
    localparam int DEPTH  = 8;
    localparam int GAP    = 2;
    localparam int MSC    = CLK_HZ / 1000;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_note;
    logic [10:0] wr_dur;
    logic        stop;
    logic        full;
    logic [3:0]  level;
    logic        busy;
    logic        ovf;
    logic [28:0] max_cont;
    logic        tone_en;

    parlante_seq #(
        .CLK_HZ     (CLK_HZ),
        .FIFO_DEPTH (DEPTH),
        .GAP_MS     (GAP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_note  (wr_note),
        .wr_dur   (wr_dur),
        .stop     (stop),
        .full     (full),
        .level    (level),
        .busy     (busy),
        .ovf      (ovf),
        .max_cont (max_cont),
        .tone_en  (tone_en)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests;
    int n_fail;

    // Reference model: activity kind + remaining cycles, queue of {note,dur}
    int          mtab [32];
    logic [15:0] mq [$];
    int          m_mode;   // 0 idle, 1 fetching, 2 sounding, 3 silent gap
    int          m_rem;
    int          m_cont;
    bit          m_tone;
    bit          m_ovf;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int   pre;
        bit   popping;
        logic [15:0] h;
        int   n;
        int   d;
        if (!rst_n) begin
            mq.delete();
            m_mode = 0; m_rem = 0; m_cont = 0; m_tone = 0; m_ovf = 0;
            return;
        end
        if (stop) begin
            mq.delete();
            m_mode = 0; m_rem = 0; m_tone = 0; m_ovf = 0;
            return;
        end
        pre     = mq.size();
        popping = (m_mode == 1);
        case (m_mode)
            0: if (pre > 0) m_mode = 1;
            1: begin
                h = mq.pop_front();
                n = int'(h[15:11]);
                d = int'(h[10:0]);
                if (d == 0) begin
                    m_mode = (mq.size() > 0) ? 1 : 0;
                end else begin
                    m_tone = (mtab[n] != 0);
                    if (mtab[n] != 0) m_cont = mtab[n];
                    m_rem  = d * MSC;
                    m_mode = 2;
                end
            end
            2: begin
                m_rem--;
                if (m_rem == 0) begin
                    m_tone = 0;
                    if (GAP > 0) begin
                        m_mode = 3;
                        m_rem  = GAP * MSC;
                    end else begin
                        m_mode = (pre > 0) ? 1 : 0;
                    end
                end
            end
            default: begin
                m_rem--;
                if (m_rem == 0) m_mode = (pre > 0) ? 1 : 0;
            end
        endcase
        if (wr_en) begin
            if (pre < DEPTH || popping) mq.push_back({wr_note, wr_dur});
            else m_ovf = 1;
        end
    endtask

    task automatic compare();
        chk("tone_en",  int'(tone_en),  int'(m_tone));
        chk("max_cont", int'(max_cont), m_cont);
        chk("level",    int'(level),    mq.size());
        chk("full",     int'(full),     int'(mq.size() == DEPTH));
        chk("ovf",      int'(ovf),      int'(m_ovf));
        chk("busy",     int'(busy),     int'(m_mode != 0 || mq.size() > 0));
    endtask

    // One clock cycle: model follows the edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic push(input int n, input int d);
        wr_en   = 1'b1;
        wr_note = 5'(n);
        wr_dur  = 11'(d);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (busy && k < 2000) begin
            tick();
            k++;
        end
        chk("drain_idle", int'(busy), 0);
    endtask

    initial begin
        int   n;
        int   hi;
        int   lo;
        int   c;
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 32; i++) begin
            if (i >= 1 && i <= 24)
                mtab[i] = $rtoi(real'(CLK_HZ) / (2.0 * 261.63 * (2.0 ** (real'(i - 1) / 12.0))) + 0.5);
            else
                mtab[i] = 0;
        end
        m_mode = 0; m_rem = 0; m_cont = 0; m_tone = 0; m_ovf = 0;
        rst_n = 1'b0; wr_en = 1'b0; wr_note = '0; wr_dur = '0; stop = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_tone", int'(tone_en), 0);
        chk("rst_cont", int'(max_cont), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_busy", int'(busy), 0);

        // Single note C4 for 3 ms
        push(1, 3);
        n = 0;
        while (!tone_en && n < 50) begin tick(); n++; end
        chk("t1_latency", n, 2);
        chk("t1_cont", int'(max_cont), 19);
        hi = 0;
        while (tone_en && hi < 1000) begin hi++; tick(); end
        chk("t1_high", hi, 30);
        lo = 0;
        while (busy && lo < 1000) begin lo++; tick(); end
        chk("t1_gap", lo, 20);

        // Note, rest, note
        push(10, 2);
        push(0, 2);
        push(13, 1);
        hi = 0;
        while (tone_en && hi < 1000) begin hi++; tick(); end
        chk("t2_high1", hi, 20);
        lo = 0;
        while (!tone_en && lo < 1000) begin
            if (lo == 30) chk("t2_rest_cont", int'(max_cont), 11);
            lo++;
            tick();
        end
        chk("t2_low", lo, 62);
        chk("t2_cont13", int'(max_cont), 10);
        hi = 0;
        while (tone_en && hi < 1000) begin hi++; tick(); end
        chk("t2_high2", hi, 10);
        drain();

        // Zero-duration entry skipped
        push(5, 0);
        push(7, 1);
        n = 1;
        while (!tone_en && n < 50) begin tick(); n++; end
        chk("t3_latency", n, 3);
        drain();

        // Overflow, then a write accepted while full because LOAD pops
        wr_en = 1'b1; wr_note = 5'd1; wr_dur = 11'd1;
        for (int i = 0; i < 12; i++) tick();
        wr_en = 1'b0;
        chk("t4_level", int'(level), 8);
        chk("t4_full", int'(full), 1);
        chk("t4_ovf", int'(ovf), 1);
        n = 0;
        while (tone_en && n < 100) begin tick(); n++; end
        for (int i = 0; i < 20; i++) tick();
        push(2, 1);
        chk("t4_level_pop", int'(level), 8);
        chk("t4_full_pop", int'(full), 1);

        // Stop mid-note with a simultaneous write
        n = 0;
        while (!tone_en && n < 200) begin tick(); n++; end
        tick(); tick(); tick();
        c = int'(max_cont);
        stop = 1'b1;
        push(3, 4);
        stop = 1'b0;
        chk("t5_tone", int'(tone_en), 0);
        chk("t5_level", int'(level), 0);
        chk("t5_ovf", int'(ovf), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_cont", int'(max_cont), c);

        // Reset during the gap
        push(1, 1);
        n = 0;
        while (!tone_en && n < 50) begin tick(); n++; end
        n = 0;
        while (tone_en && n < 100) begin tick(); n++; end
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_cont", int'(max_cont), 0);
        chk("t6_tone", int'(tone_en), 0);
        chk("t6_busy", int'(busy), 0);
        push(13, 1);
        n = 0;
        while (!tone_en && n < 50) begin tick(); n++; end
        chk("t6_latency", n, 2);
        chk("t6_cont13", int'(max_cont), 10);
        hi = 0;
        while (tone_en && hi < 1000) begin hi++; tick(); end
        chk("t6_high", hi, 10);
        drain();

        // Randomized traffic
        for (int i = 0; i < 5000; i++) begin
            wr_en   = ($urandom_range(0, 5) == 0);
            wr_note = 5'($urandom_range(0, 31));
            wr_dur  = 11'($urandom_range(0, 3));
            stop    = ($urandom_range(0, 399) == 0);
            rst_n   = !($urandom_range(0, 1499) == 0);
            tick();
        end
        wr_en = 1'b0; stop = 1'b0; rst_n = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
